// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: register-file write port, load widths, FSM states.
package writeback_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] rv_reg_t;

    typedef struct packed {
        logic            enable;
        rv_reg_t         which_register;
        logic [XLEN-1:0] value;
    } reg_write_control_t;

    // RISC-V load funct3 encodings; 011, 110 and 111 are illegal.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_width_t;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wb_state_t;

endpackage

// File: rtl/writeback_stage_load_aligner.sv
// Combinational load aligner: selects byte/half/word, extends it, and flags misaligned or illegal loads.
module writeback_stage_load_aligner
    import writeback_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_value,
    output logic            o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_value = '0;
        o_fault = 1'b0;
        case (i_funct3)
            LB:  o_value = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU: o_value = {{(XLEN-8){1'b0}}, w_byte};
            LH: begin
                o_value = {{(XLEN-16){w_half[15]}}, w_half};
                o_fault = i_addr_lo[0];
            end
            LHU: begin
                o_value = {{(XLEN-16){1'b0}}, w_half};
                o_fault = i_addr_lo[0];
            end
            LW: begin
                o_value = i_word;
                o_fault = (i_addr_lo != 2'b00);
            end
            default: o_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results and aligned loads to the register-file write port.
// Optional macro WB_RETIRE_COUNTER_EN adds a 64-bit retire_count output.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  rv_reg_t            in_rd,
    input  logic [XLEN-1:0]    in_value,
    input  logic               in_is_load,
    input  logic [2:0]         in_load_funct3,
    input  logic [1:0]         in_addr_lo,
    input  logic               mem_rsp_valid,
    input  logic [XLEN-1:0]    mem_rsp_data,
    output reg_write_control_t write_control,
    output logic               load_fault,
    output logic               timeout_fault
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [63:0]        retire_count
`endif
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    wb_state_t          r_state;
    logic               r_ready;
    logic [15:0]        r_count;
    rv_reg_t            r_rd;
    logic [2:0]         r_funct3;
    logic [1:0]         r_addr_lo;
    reg_write_control_t r_write;
    logic               r_load_fault;
    logic               r_timeout_fault;

    logic            w_accept;
    logic            w_waiting;
    logic [2:0]      w_al_funct3;
    logic [1:0]      w_al_addr_lo;
    logic [XLEN-1:0] w_al_value;
    logic            w_al_fault;

    assign w_waiting = (r_state == S_WAIT_LOAD);
    assign w_accept  = in_valid && r_ready && !w_waiting;

    // One aligner serves both the acceptance check (live inputs) and the response (held load).
    assign w_al_funct3  = w_waiting ? r_funct3  : in_load_funct3;
    assign w_al_addr_lo = w_waiting ? r_addr_lo : in_addr_lo;

    writeback_stage_load_aligner u_load_aligner (
        .i_word    (mem_rsp_data),
        .i_funct3  (w_al_funct3),
        .i_addr_lo (w_al_addr_lo),
        .o_value   (w_al_value),
        .o_fault   (w_al_fault)
    );

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ready         <= 1'b0;
            r_count         <= '0;
            r_rd            <= '0;
            r_funct3        <= '0;
            r_addr_lo       <= '0;
            r_write         <= '0;
            r_load_fault    <= 1'b0;
            r_timeout_fault <= 1'b0;
        end else begin
            r_write.enable  <= 1'b0;
            r_load_fault    <= 1'b0;
            r_timeout_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        if (!in_is_load) begin
                            r_write <= '{enable: (in_rd != '0), which_register: in_rd, value: in_value};
                        end else if (w_al_fault) begin
                            r_load_fault <= 1'b1;
                        end else begin
                            r_state   <= S_WAIT_LOAD;
                            r_ready   <= 1'b0;
                            r_count   <= '0;
                            r_rd      <= in_rd;
                            r_funct3  <= in_load_funct3;
                            r_addr_lo <= in_addr_lo;
                        end
                    end
                end
                S_WAIT_LOAD: begin
                    if (mem_rsp_valid) begin
                        r_write <= '{enable: (r_rd != '0), which_register: r_rd, value: w_al_value};
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else if (r_count == TIMEOUT_LAST) begin
                        r_timeout_fault <= 1'b1;
                        r_state         <= S_IDLE;
                        r_ready         <= 1'b1;
                    end else begin
                        r_count <= r_count + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready      = r_ready;
    assign write_control = r_write;
    assign load_fault    = r_load_fault;
    assign timeout_fault = r_timeout_fault;

`ifdef WB_RETIRE_COUNTER_EN
    logic        w_retire;
    logic [63:0] r_retire_count;

    // x0 writes still retire; faults and timeouts do not.
    assign w_retire = (w_accept && !in_is_load) || (w_waiting && mem_rsp_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_retire_count <= '0;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 64'd1;
        end
    end

    assign retire_count = r_retire_count;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic against a reference model.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    localparam int unsigned TMO = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    rv_reg_t            in_rd;
    logic [31:0]        in_value;
    logic               in_is_load;
    logic [2:0]         in_load_funct3;
    logic [1:0]         in_addr_lo;
    logic               mem_rsp_valid;
    logic [31:0]        mem_rsp_data;
    reg_write_control_t write_control;
    logic               load_fault;
    logic               timeout_fault;
`ifdef WB_RETIRE_COUNTER_EN
    logic [63:0]        retire_count;
`endif

    writeback_stage #(.MEM_TIMEOUT(TMO)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_value       (in_value),
        .in_is_load     (in_is_load),
        .in_load_funct3 (in_load_funct3),
        .in_addr_lo     (in_addr_lo),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .write_control  (write_control),
        .load_fault     (load_fault),
        .timeout_fault  (timeout_fault)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retire_count   (retire_count)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: loaded value from plain arithmetic on the memory word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && a != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Model state: one pending load at most, plus the expected registered outputs.
    bit          m_busy;
    rv_reg_t     m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_a;
    int          m_waited;
    bit          m_ready;
    bit          e_en;
    bit          e_lf;
    bit          e_tf;
    rv_reg_t     e_rd;
    logic [31:0] e_val;
    logic [63:0] m_cnt;

    // Advance one clock: update the model from the current inputs, clock the DUT, compare everything.
    task automatic cycle(input string tag);
        e_en = 1'b0;
        e_lf = 1'b0;
        e_tf = 1'b0;
        if (reset) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            e_rd    = '0;
            e_val   = '0;
            m_cnt   = '0;
        end else if (!m_busy) begin
            if (in_valid && m_ready) begin
                if (!in_is_load) begin
                    e_en  = (in_rd != 0);
                    e_rd  = in_rd;
                    e_val = in_value;
                    m_cnt = m_cnt + 1;
                end else if (ref_bad(in_load_funct3, in_addr_lo)) begin
                    e_lf = 1'b1;
                end else begin
                    m_busy   = 1'b1;
                    m_rd     = in_rd;
                    m_f3     = in_load_funct3;
                    m_a      = in_addr_lo;
                    m_waited = 0;
                end
            end
            m_ready = !m_busy;
        end else begin
            m_waited++;
            if (mem_rsp_valid) begin
                e_en   = (m_rd != 0);
                e_rd   = m_rd;
                e_val  = ref_load(m_f3, m_a, mem_rsp_data);
                m_busy = 1'b0;
                m_cnt  = m_cnt + 1;
            end else if (m_waited == TMO) begin
                e_tf   = 1'b1;
                m_busy = 1'b0;
            end
            m_ready = !m_busy;
        end
        @(posedge clock);
        @(negedge clock);
        check({tag, ".ready"}, in_ready, m_ready);
        check({tag, ".en"}, write_control.enable, e_en);
        check({tag, ".rd"}, write_control.which_register, e_rd);
        check({tag, ".val"}, write_control.value, e_val);
        check({tag, ".lfault"}, load_fault, e_lf);
        check({tag, ".tfault"}, timeout_fault, e_tf);
`ifdef WB_RETIRE_COUNTER_EN
        check({tag, ".rcount"}, retire_count, m_cnt);
`endif
    endtask

    task automatic drive(input bit v, input bit ld, input rv_reg_t rd, input logic [31:0] val,
                         input logic [2:0] f3, input logic [1:0] a);
        in_valid       = v;
        in_is_load     = ld;
        in_rd          = rd;
        in_value       = val;
        in_load_funct3 = f3;
        in_addr_lo     = a;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0);
    endtask

    localparam logic [31:0] WORD = 32'h80F1_7F02;

    // Accept a load, wait one cycle, respond, and check the retired value against a constant.
    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] a,
                             input logic [31:0] exp);
        drive(1'b1, 1'b1, 5'd9, 32'h5555_5555, f3, a);
        cycle({tag, "_acc"});
        check({tag, "_busy"}, in_ready, 1'b0);
        idle_in();
        cycle({tag, "_wait"});
        mem_rsp_valid = 1'b1;
        cycle({tag, "_rsp"});
        mem_rsp_valid = 1'b0;
        check({tag, "_en"}, write_control.enable, 1'b1);
        check({tag, "_value"}, write_control.value, exp);
        check({tag, "_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] base;
        reset         = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = WORD;
        idle_in();

        cycle("rst0");
        cycle("rst1");
        check("rst_en", write_control.enable, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        reset = 1'b0;
        cycle("post_rst");
        check("ready_after_rst", in_ready, 1'b1);

        drive(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 3'd0, 2'd0);
        cycle("alu5");
        check("alu5_en", write_control.enable, 1'b1);
        check("alu5_rd", write_control.which_register, 5'd5);
        check("alu5_val", write_control.value, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 5'd0, 32'h1234_5678, 3'd0, 2'd0);
        cycle("alu0");
        check("alu0_en", write_control.enable, 1'b0);
        idle_in();
        cycle("idle0");

        load_case("lb3", 3'b000, 2'd3, 32'hFFFF_FF80);
        load_case("lbu1", 3'b100, 2'd1, 32'h0000_007F);
        load_case("lh2", 3'b001, 2'd2, 32'hFFFF_80F1);
        load_case("lw0", 3'b010, 2'd0, 32'h80F1_7F02);

        drive(1'b1, 1'b1, 5'd3, 32'd0, 3'b010, 2'd2);
        cycle("lw_mis");
        check("lw_mis_fault", load_fault, 1'b1);
        check("lw_mis_en", write_control.enable, 1'b0);
        check("lw_mis_ready", in_ready, 1'b1);
        drive(1'b1, 1'b1, 5'd3, 32'd0, 3'b011, 2'd0);
        cycle("f3_ill");
        check("f3_ill_fault", load_fault, 1'b1);
        idle_in();
        cycle("idle1");

        // Timeout with a late response that must be ignored.
        drive(1'b1, 1'b1, 5'd4, 32'd0, 3'b010, 2'd0);
        cycle("tmo_acc");
        idle_in();
        for (int i = 0; i < int'(TMO) - 1; i++) begin
            cycle("tmo_wait");
            check("tmo_early", timeout_fault, 1'b0);
        end
        cycle("tmo_hit");
        check("tmo_fault", timeout_fault, 1'b1);
        check("tmo_en", write_control.enable, 1'b0);
        check("tmo_ready", in_ready, 1'b1);
        cycle("tmo_gap");
        mem_rsp_valid = 1'b1;
        cycle("tmo_late");
        mem_rsp_valid = 1'b0;
        check("tmo_late_en", write_control.enable, 1'b0);

        // Response arriving on the timeout cycle wins.
        drive(1'b1, 1'b1, 5'd6, 32'd0, 3'b010, 2'd0);
        cycle("race_acc");
        idle_in();
        for (int i = 0; i < int'(TMO) - 1; i++) cycle("race_wait");
        mem_rsp_valid = 1'b1;
        cycle("race_hit");
        mem_rsp_valid = 1'b0;
        check("race_en", write_control.enable, 1'b1);
        check("race_fault", timeout_fault, 1'b0);

        // Reset during WAIT_LOAD discards the pending load.
        drive(1'b1, 1'b1, 5'd7, 32'd0, 3'b010, 2'd0);
        cycle("rstw_acc");
        idle_in();
        reset = 1'b1;
        cycle("rstw_rst");
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        cycle("rstw_rsp");
        mem_rsp_valid = 1'b0;
        check("rstw_en", write_control.enable, 1'b0);
        check("rstw_ready", in_ready, 1'b1);

`ifdef WB_RETIRE_COUNTER_EN
        base = retire_count;
        drive(1'b1, 1'b0, 5'd1, 32'd1, 3'd0, 2'd0); cycle("cnt_a1");
        drive(1'b1, 1'b0, 5'd0, 32'd2, 3'd0, 2'd0); cycle("cnt_a2");
        drive(1'b1, 1'b0, 5'd2, 32'd3, 3'd0, 2'd0); cycle("cnt_a3");
        drive(1'b1, 1'b1, 5'd3, 32'd0, 3'b010, 2'd0); cycle("cnt_ld");
        idle_in();
        mem_rsp_valid = 1'b1; cycle("cnt_rsp"); mem_rsp_valid = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 32'd0, 3'b001, 2'd1); cycle("cnt_flt");
        idle_in();
        cycle("cnt_idle");
        check("cnt_delta", retire_count - base, 64'd4);
`else
        base = '0;
`endif

        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            in_valid       = ($urandom_range(0, 9) < 7);
            in_is_load     = $urandom_range(0, 1) != 0;
            in_rd          = rv_reg_t'($urandom_range(0, 31));
            in_value       = $urandom;
            in_load_funct3 = 3'($urandom_range(0, 7));
            in_addr_lo     = 2'($urandom_range(0, 3));
            mem_rsp_valid  = ($urandom_range(0, 3) == 0);
            mem_rsp_data   = $urandom;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
